setup_sequencer: RTL and testbench

//  Front-end controller for the triangle setup unit. Accepts assembled triangles (v0,v1,v2) over a

---
 rtl/setup_sequencer_if.sv | 39 +++
 rtl/setup_sequencer.sv | 92 +++++++++
 tb/tb_setup_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/setup_sequencer_if.sv
// Shared vertex/setup record types and the sequencer's bus bundle
// (upstream triangle handshake, setup-unit link, rasterizer handshake).
package setup_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } vertex_t;

  typedef struct packed {
    logic               valid;  // non-degenerate
    logic               ccw;    // counter-clockwise winding
    logic signed [31:0] area;   // twice the signed area
  } triangle_setup_t;
endpackage

interface setup_sequencer_if;
  import setup_pkg::*;
  logic            in_valid, in_ready;
  vertex_t         in_v0, in_v1, in_v2;
  logic [1:0]      cull_mode;
  vertex_t         setup_v0, setup_v1, setup_v2;
  logic            setup_start, setup_busy, setup_done;
  triangle_setup_t setup_result;
  logic            out_valid, out_ready;
  triangle_setup_t out_setup;

  modport slave (
    input  in_valid, in_v0, in_v1, in_v2, cull_mode,
           setup_busy, setup_done, setup_result, out_ready,
    output in_ready, setup_v0, setup_v1, setup_v2, setup_start,
           out_valid, out_setup
  );
  modport master (
    output in_valid, in_v0, in_v1, in_v2, cull_mode,
           setup_busy, setup_done, setup_result, out_ready,
    input  in_ready, setup_v0, setup_v1, setup_v2, setup_start,
           out_valid, out_setup
  );
endinterface

// File: rtl/setup_sequencer.sv
// Triangle setup front-end: accept, launch setup, wait with watchdog,
// cull by validity/facing, forward surviving records, keep statistics.
module setup_sequencer
  import setup_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  setup_sequencer_if.slave bus,
  input  logic             flush,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] tri_count,
  output logic [CNT_W-1:0] cull_count,
  output logic             timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, OUTPUT = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [1:0]  cmode;
  logic [31:0] wdog;
  logic        rdy_q;
  logic        accept, drop_c, wd_fire, done_w;

  // Ready is a registered decode of the next state, so it is low in reset
  // and never depends on in_valid.
  assign bus.in_ready    = rdy_q;
  assign bus.setup_start = (state == LAUNCH) && !bus.setup_busy && !flush;
  assign bus.out_valid   = (state == OUTPUT) && !flush;

  // flush wins over a same-cycle accept; the triangle is not taken
  assign accept  = rdy_q && bus.in_valid && !flush;
  assign done_w  = (state == WAIT) && bus.setup_done && !flush;
  assign drop_c  = !bus.setup_result.valid
                 || (cmode == 2'd1 && !bus.setup_result.ccw)
                 || (cmode == 2'd2 &&  bus.setup_result.ccw);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (wdog == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = LAUNCH;
        LAUNCH:  if (!bus.setup_busy) state_nxt = WAIT;
        WAIT:    if (bus.setup_done) state_nxt = drop_c ? IDLE : OUTPUT;
                 else if (wd_fire) state_nxt = IDLE;
        OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      cmode        <= 2'd0;
      wdog         <= '0;
      bus.setup_v0 <= '0;
      bus.setup_v1 <= '0;
      bus.setup_v2 <= '0;
      bus.out_setup <= '0;
      tri_count    <= '0;
      cull_count   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (accept) begin
        bus.setup_v0 <= bus.in_v0;
        bus.setup_v1 <= bus.in_v1;
        bus.setup_v2 <= bus.in_v2;
        cmode        <= bus.cull_mode;
      end
      // watchdog restarts on every entry into WAIT
      if (state == LAUNCH)    wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 32'd1;
      if (done_w && !drop_c) bus.out_setup <= bus.setup_result;
      if (clr_stats) begin
        tri_count   <= '0;
        cull_count  <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (accept)          tri_count  <= tri_count + 1'b1;
        if (done_w && drop_c) cull_count <= cull_count + 1'b1;
        if ((state == WAIT) && !bus.setup_done && wd_fire && !flush) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_setup_sequencer.sv
// Scoreboard bench for setup_sequencer with a behavioural setup-unit stub.
module tb_setup_sequencer;
  import setup_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, clr_stats = 1'b0;
  logic [31:0] tri_count, cull_count;
  logic        timeout_err;
  logic        hang = 1'b0;
  logic [2:0]  lat_cnt;
  int          errs = 0, checks = 0;
  triangle_setup_t exp_q[$];

  setup_sequencer_if bus();

  setup_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .flush(flush),
    .clr_stats(clr_stats), .tri_count(tri_count), .cull_count(cull_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic vertex_t vx(input int x, input int y);
    vertex_t r;
    r.x = 16'(x);
    r.y = 16'(y);
    return r;
  endfunction

  function automatic triangle_setup_t mk(input logic v, input logic c, input int a);
    triangle_setup_t r;
    r.valid = v;
    r.ccw   = c;
    r.area  = 32'(a);
    return r;
  endfunction

  // Stub setup unit: 3-cycle latency, computes the winding cross product.
  function automatic triangle_setup_t calc(input vertex_t a, input vertex_t b, input vertex_t c);
    logic signed [31:0] dx1, dy1, dx2, dy2, ar;
    dx1 = 32'(b.x) - 32'(a.x);
    dy1 = 32'(b.y) - 32'(a.y);
    dx2 = 32'(c.x) - 32'(a.x);
    dy2 = 32'(c.y) - 32'(a.y);
    ar  = dx1 * dy2 - dx2 * dy1;
    return mk(ar != 0, ar > 0, int'(ar));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.setup_busy   <= 1'b0;
      bus.setup_done   <= 1'b0;
      bus.setup_result <= '0;
      lat_cnt          <= '0;
    end else begin
      bus.setup_done <= 1'b0;
      if (flush) begin
        lat_cnt        <= '0;
        bus.setup_busy <= 1'b0;
      end else if (bus.setup_start && !hang) begin
        lat_cnt        <= 3'd3;
        bus.setup_busy <= 1'b1;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          bus.setup_done   <= 1'b1;
          bus.setup_busy   <= 1'b0;
          bus.setup_result <= calc(bus.setup_v0, bus.setup_v1, bus.setup_v2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rasterizer handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got %0h, expected no record", bus.out_setup);
      end else begin
        chk("out_setup", 128'(bus.out_setup), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vertex_t a, input vertex_t b, input vertex_t c, input logic [1:0] m);
    int n = 0;
    while (!bus.in_ready && n < 100) begin step(); n++; end
    chk("ready_before_send", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_v0 = a; bus.in_v1 = b; bus.in_v2 = c; bus.cull_mode = m;
    step();
    bus.in_valid = 1'b0;
    chk("start_after_accept", bus.setup_start, 1);
    chk("setup_v_latched", {bus.setup_v0, bus.setup_v1, bus.setup_v2}, {a, b, c});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin step(); n++; end
    chk("idle_reached", bus.in_ready, 1);
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_stats", {timeout_err, tri_count, cull_count}, 0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cull_mode = 2'd0;
    bus.in_v0 = '0; bus.in_v1 = '0; bus.in_v2 = '0;
    #12;
    chk("reset_outs", {bus.in_ready, bus.out_valid, bus.setup_start, timeout_err}, 0);
    chk("reset_cnt", {tri_count, cull_count}, 0);
    chk("reset_regs", {bus.setup_v0, bus.setup_v1, bus.setup_v2, bus.out_setup}, 0);
    rst_n = 1'b1;
    step(); step();
    chk("ready_after_reset", bus.in_ready, 1);

    // 1: CCW triangle forwarded, done -> out_valid in one cycle
    exp_q.push_back(mk(1, 1, 100));
    send(vx(0,0), vx(10,0), vx(0,10), 2'd0);
    n = 0;
    while (!bus.setup_done && n < 20) begin step(); n++; end
    step();
    chk("out_valid_after_done", bus.out_valid, 1);
    wait_idle();
    chk("t1_counts", {tri_count, cull_count}, {32'd1, 32'd0});

    // 2: CCW culled in mode 2; swapped winding passes with ccw=0
    send(vx(0,0), vx(10,0), vx(0,10), 2'd2);
    wait_idle();
    chk("t2_cull_counts", {tri_count, cull_count}, {32'd2, 32'd1});
    exp_q.push_back(mk(1, 0, -100));
    send(vx(0,0), vx(0,10), vx(10,0), 2'd2);
    wait_idle();
    chk("t2_pass_counts", {tri_count, cull_count}, {32'd3, 32'd1});

    // 3: collinear triangle is degenerate and dropped
    pulse_clr();
    send(vx(0,0), vx(5,5), vx(10,10), 2'd0);
    wait_idle();
    chk("t3_counts", {tri_count, cull_count}, {32'd1, 32'd1});

    // 4: back-pressure holds the record
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(1, 1, 100));
    send(vx(0,0), vx(10,0), vx(0,10), 2'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 20; i++) begin
      chk("hold_out", {bus.out_valid, bus.in_ready, bus.out_setup}, {1'b1, 1'b0, mk(1, 1, 100)});
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("idle_after_handshake", {bus.in_ready, bus.out_valid}, 2'b10);

    // 5: watchdog fires after 64 WAIT cycles
    hang = 1'b1;
    send(vx(0,0), vx(10,0), vx(0,10), 2'd0);
    repeat (64) step();
    chk("wd_not_yet", {timeout_err, bus.in_ready}, 2'b00);
    step();
    chk("wd_fired", {timeout_err, bus.in_ready}, 2'b11);
    chk("wd_no_cull", cull_count, 1);
    pulse_clr();

    // 6a: reset during WAIT
    send(vx(0,0), vx(10,0), vx(0,10), 2'd0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("rst_wait_outs", {bus.in_ready, bus.out_valid, bus.setup_start, timeout_err}, 0);
    chk("rst_wait_regs", {bus.setup_v0, bus.setup_v1, bus.setup_v2, bus.out_setup, tri_count}, 0);
    hang = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(mk(1, 1, 100));
    send(vx(0,0), vx(10,0), vx(0,10), 2'd0);
    wait_idle();
    chk("post_rst_counts", {tri_count, cull_count}, {32'd1, 32'd0});

    // 6b: flush during OUTPUT drops the record
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(1, 0, -100));
    send(vx(0,0), vx(0,10), vx(10,0), 2'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    chk("flush_pre_valid", bus.out_valid, 1);
    flush = 1'b1;
    #1;
    chk("flush_forces_low", {bus.out_valid, bus.setup_start}, 0);
    void'(exp_q.pop_back());
    step();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    exp_q.push_back(mk(1, 1, 100));
    send(vx(0,0), vx(10,0), vx(0,10), 2'd1);
    wait_idle();
    chk("post_flush_counts", {tri_count, cull_count}, {32'd3, 32'd0});

    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
